// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Main control FSM for a multicycle RV32 datapath. It sequences
//                fetch, decode, execute, memory and writeback steps, bounds
//                every memory wait with a timeout, and parks in a sticky TRAP
//                state on illegal decode or memory timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       iClk,
   input  logic       iRstN,
   input  logic [9:1] iInstrType,
   input  logic       iBranchTaken,
   input  logic       iMemReady,
   output logic       oPCWrite,
   output logic       oIRWrite,
   output logic       oRegWrite,
   output logic       oMemRead,
   output logic       oMemWrite,
   output logic [1:0] oAluSrcA,
   output logic [1:0] oAluSrcB,
   output logic [1:0] oAluOp,
   output logic [1:0] oResultSrc,
   output logic [3:0] oState,
   output logic       oTrap
);

   // State encoding (externally visible on oState)
   localparam logic [3:0] c_FETCH  = 4'd0;
   localparam logic [3:0] c_DECODE = 4'd1;
   localparam logic [3:0] c_MEMADR = 4'd2;
   localparam logic [3:0] c_MEMRD  = 4'd3;
   localparam logic [3:0] c_MEMWB  = 4'd4;
   localparam logic [3:0] c_MEMWR  = 4'd5;
   localparam logic [3:0] c_EXECR  = 4'd6;
   localparam logic [3:0] c_EXECI  = 4'd7;
   localparam logic [3:0] c_ALUWB  = 4'd8;
   localparam logic [3:0] c_BRANCH = 4'd9;
   localparam logic [3:0] c_JAL    = 4'd10;
   localparam logic [3:0] c_JALR   = 4'd11;
   localparam logic [3:0] c_LUI    = 4'd12;
   localparam logic [3:0] c_AUIPC  = 4'd13;
   localparam logic [3:0] c_TRAP   = 4'd15;

   // Operand / operation / writeback select encodings
   localparam logic [1:0] c_A_PC     = 2'b00;
   localparam logic [1:0] c_A_RS1    = 2'b01;
   localparam logic [1:0] c_B_RS2    = 2'b00;
   localparam logic [1:0] c_B_IMM    = 2'b01;
   localparam logic [1:0] c_B_FOUR   = 2'b10;
   localparam logic [1:0] c_OP_ADD   = 2'b00;
   localparam logic [1:0] c_OP_CMP   = 2'b01;
   localparam logic [1:0] c_OP_FUNCT = 2'b10;
   localparam logic [1:0] c_RES_ALU  = 2'b00;
   localparam logic [1:0] c_RES_MEM  = 2'b01;
   localparam logic [1:0] c_RES_PC4  = 2'b10;
   localparam logic [1:0] c_RES_IMM  = 2'b11;

   // Counter is wide enough to hold MEM_TIMEOUT-1 even for tiny timeouts
   localparam int              c_CW        = $clog2(MEM_TIMEOUT + 1);
   localparam logic [c_CW-1:0] c_WAIT_LAST = c_CW'(MEM_TIMEOUT - 1);

   logic [3:0]      r_state;
   logic [3:0]      w_next;
   logic [c_CW-1:0] r_wait_cnt;
   logic            r_is_load;
   logic            w_onehot;
   logic            w_wait_state;
   logic            w_timeout;

   assign w_onehot     = (iInstrType != 9'd0) &&
                         ((iInstrType & (iInstrType - 9'd1)) == 9'd0);
   assign w_wait_state = (r_state == c_FETCH) || (r_state == c_MEMRD) ||
                         (r_state == c_MEMWR);
   // Ready in the final allowed cycle still wins over the timeout
   assign w_timeout    = !iMemReady && (r_wait_cnt == c_WAIT_LAST);

   // Next-state decode
   always_comb begin
      w_next = c_TRAP;
      case (r_state)
         c_FETCH: begin
            if (iMemReady)      w_next = c_DECODE;
            else if (w_timeout) w_next = c_TRAP;
            else                w_next = c_FETCH;
         end
         c_DECODE: begin
            if (!w_onehot)           w_next = c_TRAP;
            else if (iInstrType[9])  w_next = c_BRANCH;
            else if (iInstrType[8])  w_next = c_JALR;
            else if (iInstrType[7])  w_next = c_JAL;
            else if (iInstrType[6])  w_next = c_EXECR;
            else if (iInstrType[5])  w_next = c_AUIPC;
            else if (iInstrType[4])  w_next = c_LUI;
            else if (iInstrType[3])  w_next = c_EXECI;
            else                     w_next = c_MEMADR;
         end
         c_MEMADR: w_next = r_is_load ? c_MEMRD : c_MEMWR;
         c_MEMRD: begin
            if (iMemReady)      w_next = c_MEMWB;
            else if (w_timeout) w_next = c_TRAP;
            else                w_next = c_MEMRD;
         end
         c_MEMWR: begin
            if (iMemReady)      w_next = c_FETCH;
            else if (w_timeout) w_next = c_TRAP;
            else                w_next = c_MEMWR;
         end
         c_MEMWB, c_ALUWB, c_BRANCH, c_JAL,
         c_JALR, c_LUI, c_AUIPC: w_next = c_FETCH;
         c_EXECR, c_EXECI:       w_next = c_ALUWB;
         default:                w_next = c_TRAP;   // TRAP and unused code 14
      endcase
   end

   // State register, wait counter and latched load/store class
   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         r_state    <= c_FETCH;
         r_wait_cnt <= '0;
         r_is_load  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_wait_cnt <= '0;
         else if (w_wait_state && !iMemReady)
            r_wait_cnt <= r_wait_cnt + 1'b1;
         if (r_state == c_DECODE)
            r_is_load <= iInstrType[2];
      end
   end

   // Output decode: purely a function of current state and inputs
   always_comb begin
      oPCWrite   = 1'b0;
      oIRWrite   = 1'b0;
      oRegWrite  = 1'b0;
      oMemRead   = 1'b0;
      oMemWrite  = 1'b0;
      oAluSrcA   = c_A_PC;
      oAluSrcB   = c_B_RS2;
      oAluOp     = c_OP_ADD;
      oResultSrc = c_RES_ALU;
      case (r_state)
         c_FETCH: begin
            oMemRead = 1'b1;
            oAluSrcA = c_A_PC;
            oAluSrcB = c_B_FOUR;
            oIRWrite = iMemReady;
            oPCWrite = iMemReady;
         end
         c_MEMADR: begin
            oAluSrcA = c_A_RS1;
            oAluSrcB = c_B_IMM;
         end
         c_MEMRD:  oMemRead = 1'b1;
         c_MEMWB: begin
            oRegWrite  = 1'b1;
            oResultSrc = c_RES_MEM;
         end
         c_MEMWR:  oMemWrite = 1'b1;
         c_EXECR: begin
            oAluSrcA = c_A_RS1;
            oAluSrcB = c_B_RS2;
            oAluOp   = c_OP_FUNCT;
         end
         c_EXECI: begin
            oAluSrcA = c_A_RS1;
            oAluSrcB = c_B_IMM;
            oAluOp   = c_OP_FUNCT;
         end
         c_ALUWB: begin
            oRegWrite  = 1'b1;
            oResultSrc = c_RES_ALU;
         end
         c_BRANCH: begin
            oAluSrcA = c_A_RS1;
            oAluSrcB = c_B_RS2;
            oAluOp   = c_OP_CMP;
            oPCWrite = iBranchTaken;
         end
         c_JAL: begin
            oAluSrcA   = c_A_PC;
            oAluSrcB   = c_B_IMM;
            oPCWrite   = 1'b1;
            oRegWrite  = 1'b1;
            oResultSrc = c_RES_PC4;
         end
         c_JALR: begin
            oAluSrcA   = c_A_RS1;
            oAluSrcB   = c_B_IMM;
            oPCWrite   = 1'b1;
            oRegWrite  = 1'b1;
            oResultSrc = c_RES_PC4;
         end
         c_LUI: begin
            oRegWrite  = 1'b1;
            oResultSrc = c_RES_IMM;
         end
         c_AUIPC: begin
            oAluSrcA   = c_A_PC;
            oAluSrcB   = c_B_IMM;
            oRegWrite  = 1'b1;
            oResultSrc = c_RES_ALU;
         end
         default: ;   // DECODE and TRAP drive nothing
      endcase
   end

   assign oState = r_state;
   assign oTrap  = (r_state == c_TRAP);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl (MEM_TIMEOUT=4).
//                Each driven cycle pushes the expected state and output
//                bundle; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

   logic       iClk = 1'b0;
   logic       iRstN;
   logic [9:1] iInstrType;
   logic       iBranchTaken;
   logic       iMemReady;
   logic       oPCWrite, oIRWrite, oRegWrite, oMemRead, oMemWrite;
   logic [1:0] oAluSrcA, oAluSrcB, oAluOp, oResultSrc;
   logic [3:0] oState;
   logic       oTrap;

   int n_checks = 0;
   int n_errors = 0;

   logic [17:0] sb[$];
   logic [17:0] r_exp;

   multicycle_ctrl #(.MEM_TIMEOUT(4)) u_dut (
      .iClk         (iClk),
      .iRstN        (iRstN),
      .iInstrType   (iInstrType),
      .iBranchTaken (iBranchTaken),
      .iMemReady    (iMemReady),
      .oPCWrite     (oPCWrite),
      .oIRWrite     (oIRWrite),
      .oRegWrite    (oRegWrite),
      .oMemRead     (oMemRead),
      .oMemWrite    (oMemWrite),
      .oAluSrcA     (oAluSrcA),
      .oAluSrcB     (oAluSrcB),
      .oAluOp       (oAluOp),
      .oResultSrc   (oResultSrc),
      .oState       (oState),
      .oTrap        (oTrap)
   );

   always #5 iClk = ~iClk;

   task automatic check_value(input string tag, input logic [17:0] got,
                              input logic [17:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected outputs per state, written from the control table:
   // {pcw, irw, rw, mr, mw, srcA, srcB, op, res, trap}
   function automatic logic [13:0] exp_out(input logic [3:0] st,
                                           input logic rdy, input logic tk);
      case (st)
         4'd0:  return {rdy, rdy, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0};
         4'd1:  return {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
         4'd2:  return {5'b00000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
         4'd3:  return {5'b00010, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
         4'd4:  return {5'b00100, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0};
         4'd5:  return {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
         4'd6:  return {5'b00000, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0};
         4'd7:  return {5'b00000, 2'b01, 2'b01, 2'b10, 2'b00, 1'b0};
         4'd8:  return {5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
         4'd9:  return {tk, 4'b0000, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0};
         4'd10: return {5'b10100, 2'b00, 2'b01, 2'b00, 2'b10, 1'b0};
         4'd11: return {5'b10100, 2'b01, 2'b01, 2'b00, 2'b10, 1'b0};
         4'd12: return {5'b00100, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0};
         4'd13: return {5'b00100, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0};
         default: return {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
      endcase
   endfunction

   function automatic logic [9:1] cls(input int b);
      logic [9:1] v;
      v = '0;
      v[b] = 1'b1;
      return v;
   endfunction

   // Drive one cycle of inputs and record what the DUT must show this cycle
   task automatic drive(input logic rstn, input logic [9:1] ityp,
                        input logic rdy, input logic tk, input logic [3:0] est);
      iRstN        = rstn;
      iInstrType   = ityp;
      iMemReady    = rdy;
      iBranchTaken = tk;
      sb.push_back({est, exp_out(est, rdy, tk)});
      @(posedge iClk);
      #1;
   endtask

   // Monitor: compare mid-cycle, away from the active edge
   always @(negedge iClk) begin
      if (sb.size() != 0) begin
         r_exp = sb.pop_front();
         check_value($sformatf("state_exp%0d", r_exp[17:14]),
                     {14'd0, oState}, {14'd0, r_exp[17:14]});
         check_value($sformatf("outs_st%0d", r_exp[17:14]),
                     {4'd0, oPCWrite, oIRWrite, oRegWrite, oMemRead, oMemWrite,
                      oAluSrcA, oAluSrcB, oAluOp, oResultSrc, oTrap},
                     {4'd0, r_exp[13:0]});
      end
   end

   initial begin
      logic [9:1] R, I, LD, ST, BR, JL, JR, LU, AU, BAD;
      R  = cls(6); I  = cls(3); LD = cls(2); ST = cls(1); BR = cls(9);
      JL = cls(7); JR = cls(8); LU = cls(4); AU = cls(5);
      BAD = 9'b000000011;

      iRstN = 1'b0; iInstrType = '0; iBranchTaken = 1'b0; iMemReady = 1'b0;
      repeat (2) @(posedge iClk);
      #1;
      // Reset state, still in reset
      drive(0, R, 0, 0, 4'd0);

      // R-type: 0,1,6,8
      drive(1, R, 1, 0, 4'd0); drive(1, R, 0, 0, 4'd1);
      drive(1, R, 0, 0, 4'd6); drive(1, R, 0, 0, 4'd8);

      // Load: 2 fetch waits, then 3 MEMRD waits (counter must restart)
      drive(1, LD, 0, 0, 4'd0); drive(1, LD, 0, 0, 4'd0); drive(1, LD, 1, 0, 4'd0);
      drive(1, LD, 0, 0, 4'd1); drive(1, LD, 0, 0, 4'd2);
      drive(1, LD, 0, 0, 4'd3); drive(1, LD, 0, 0, 4'd3); drive(1, LD, 0, 0, 4'd3);
      drive(1, LD, 1, 0, 4'd3); drive(1, LD, 0, 0, 4'd4);

      // Branch not taken, then taken
      drive(1, BR, 1, 0, 4'd0); drive(1, BR, 0, 0, 4'd1); drive(1, BR, 0, 0, 4'd9);
      drive(1, BR, 1, 1, 4'd0); drive(1, BR, 0, 1, 4'd1); drive(1, BR, 0, 1, 4'd9);

      // JAL, JALR, LUI, AUIPC, I-type, store
      drive(1, JL, 1, 0, 4'd0); drive(1, JL, 0, 0, 4'd1); drive(1, JL, 0, 0, 4'd10);
      drive(1, JR, 1, 0, 4'd0); drive(1, JR, 0, 0, 4'd1); drive(1, JR, 0, 0, 4'd11);
      drive(1, LU, 1, 0, 4'd0); drive(1, LU, 0, 0, 4'd1); drive(1, LU, 0, 0, 4'd12);
      drive(1, AU, 1, 0, 4'd0); drive(1, AU, 0, 0, 4'd1); drive(1, AU, 0, 0, 4'd13);
      drive(1, I, 1, 0, 4'd0);  drive(1, I, 0, 0, 4'd1);  drive(1, I, 0, 0, 4'd7);
      drive(1, I, 0, 0, 4'd8);
      drive(1, ST, 1, 0, 4'd0); drive(1, ST, 0, 0, 4'd1); drive(1, ST, 0, 0, 4'd2);
      drive(1, ST, 0, 0, 4'd5); drive(1, ST, 1, 0, 4'd5);

      // Two classes set: trap, held, then cleared by one reset cycle
      drive(1, BAD, 1, 0, 4'd0); drive(1, BAD, 0, 0, 4'd1);
      drive(1, BAD, 1, 0, 4'd15); drive(1, BAD, 1, 1, 4'd15);
      drive(0, BAD, 0, 0, 4'd15); drive(1, R, 0, 0, 4'd0);

      // No class set: trap
      drive(1, '0, 1, 0, 4'd0); drive(1, '0, 0, 0, 4'd1); drive(1, '0, 0, 0, 4'd15);
      drive(0, R, 0, 0, 4'd15);

      // Fetch timeout after 4 waiting cycles
      drive(1, R, 0, 0, 4'd0); drive(1, R, 0, 0, 4'd0);
      drive(1, R, 0, 0, 4'd0); drive(1, R, 0, 0, 4'd0);
      drive(1, R, 0, 0, 4'd15); drive(0, R, 0, 0, 4'd15);

      // Ready on the 4th fetch cycle wins over timeout
      drive(1, R, 0, 0, 4'd0); drive(1, R, 0, 0, 4'd0);
      drive(1, R, 0, 0, 4'd0); drive(1, R, 1, 0, 4'd0);
      drive(1, R, 0, 0, 4'd1); drive(1, R, 0, 0, 4'd6); drive(1, R, 0, 0, 4'd8);

      // Reset during a pending store
      drive(1, ST, 1, 0, 4'd0); drive(1, ST, 0, 0, 4'd1); drive(1, ST, 0, 0, 4'd2);
      drive(1, ST, 0, 0, 4'd5); drive(0, ST, 0, 0, 4'd5);
      drive(1, ST, 0, 0, 4'd0);

      @(negedge iClk);
      #1;
      check_value("sb_drain", 18'(sb.size()), 18'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16, giving the maximum cycles spent waiting for iMemReady in any one memory state.
REQ-002 iClk  input  1  The block SHALL be clocked on the rising edge of the single clock iClk.
REQ-003 iRstN  input  1  The block SHALL use iRstN as its reset, which is synchronous and active-low.
REQ-004 iInstrType  input  9  The block SHALL take a one-hot instruction class from the opcode decoder on iInstrType: [9] branch, [8] jalr (1100111), [7] jal (1101111), [6] R-type, [5] auipc, [4] lui, [3] reg-imm, [2] load, [1] store.
REQ-005 iBranchTaken  input  1  The block SHALL treat iBranchTaken as the ALU compare result, valid in BRANCH.
REQ-006 iMemReady  input  1  The block SHALL treat iMemReady as memory completion for the current access.
REQ-007 oPCWrite, oIRWrite, oRegWrite, oMemRead, oMemWrite  output  1 each  The block SHALL drive these single-bit register and memory strobes.
REQ-008 oAluSrcA  output  2  The block SHALL select ALU operand A: 00 PC, 01 rs1, 10 zero.
REQ-009 oAluSrcB  output  2  The block SHALL select ALU operand B: 00 rs2, 01 imm, 10 constant 4.
REQ-010 oAluOp  output  2  The block SHALL set ALU operation: 00 add, 01 compare, 10 funct-decoded.
REQ-011 oResultSrc  output  2  The block SHALL select writeback data: 00 ALU, 01 memory data, 10 PC+4, 11 imm.
REQ-012 oState  output  4  The block SHALL expose the current state code on oState.
REQ-013 oTrap  output  1  The block SHALL assert oTrap to flag a sticky fault.

Function
REQ-014 The FSM SHALL use these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, AUIPC=13, TRAP=15; code 14 is unreachable and SHALL go to TRAP.
REQ-015 FETCH SHALL assert oMemRead, hold while iMemReady=0, and, in the cycle iMemReady=1, assert oIRWrite and oPCWrite (A=PC, B=4, add) before moving to DECODE.
REQ-016 DECODE SHALL move as follows: exactly one iInstrType bit set -> [9] BRANCH, [8] JALR, [7] JAL, [6] EXECR, [5] AUIPC, [4] LUI, [3] EXECI, [2] or [1] MEMADR; zero bits or more than one bit set -> TRAP.
REQ-017 MEMADR SHALL compute rs1+imm, then move to MEMRD if the class latched in DECODE is load, or MEMWR if it is store.
REQ-018 MEMRD SHALL assert oMemRead until iMemReady=1, then move to MEMWB.
REQ-019 MEMWB SHALL assert oRegWrite with oResultSrc=01, then move to FETCH.
REQ-020 MEMWR SHALL assert oMemWrite until iMemReady=1, then move to FETCH.
REQ-021 EXECR (A=rs1, B=rs2, op=10) and EXECI (A=rs1, B=imm, op=10) SHALL each move to ALUWB.
REQ-022 ALUWB SHALL assert oRegWrite with oResultSrc=00, then move to FETCH.
REQ-023 BRANCH SHALL use A=rs1, B=rs2, op=01, and SHALL set oPCWrite=iBranchTaken.
REQ-024 JAL SHALL use A=PC, B=imm, and JALR SHALL use A=rs1, B=imm; both SHALL assert oPCWrite and oRegWrite with oResultSrc=10.
REQ-025 LUI SHALL assert oRegWrite with oResultSrc=11.
REQ-026 AUIPC SHALL assert oRegWrite with A=PC, B=imm, oResultSrc=00.
REQ-027 Every one-cycle state (DECODE, MEMADR, MEMWB, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC) SHALL advance unconditionally, giving fixed latencies of 3 cycles for branch/jal/jalr/lui/auipc and 4 for R/I type, plus memory wait cycles.
REQ-028 A wait counter SHALL increment each cycle spent in FETCH, MEMRD or MEMWR with iMemReady=0, and SHALL clear on every state change.
REQ-029 If the wait counter reaches MEM_TIMEOUT-1 while iMemReady=0, the next state SHALL be TRAP; iMemReady=1 in that same cycle SHALL take precedence and complete normally.
REQ-030 TRAP SHALL deassert all strobes, hold oTrap=1, and be left only via reset.
REQ-031 All strobes SHALL be Moore/Mealy functions of state and inputs with no added pipeline latency; strobes not named for a state SHALL be 0 in that state.

Reset
REQ-032 When iRstN=0 at a rising edge, the next state SHALL be FETCH with counter=0, oTrap=0, and oState=0; all strobes SHALL be 0 except FETCH's oMemRead=1.
REQ-033 Reset SHALL override any in-progress access, wait or TRAP in the same edge.

Verification
REQ-034 R-type, iMemReady=1 in FETCH -> oState sequence 0,1,6,8,0; oRegWrite=1 only in state 8.
REQ-035 Load with MEMRD ready after 3 wait cycles -> states 0,1,2,3,3,3,3,4,0; oMemRead=1 throughout state 3.
REQ-036 Branch with iBranchTaken=0, then a second branch with iBranchTaken=1 -> oPCWrite=0 in state 9 the first time, 1 the second time.
REQ-037 iInstrType=9'b000000011 in DECODE -> state 15, oTrap=1 held; iRstN=0 one cycle -> state 0, oTrap=0.
REQ-038 MEM_TIMEOUT=4 with iMemReady held 0 in FETCH -> TRAP after 4 FETCH cycles; a repeat run with iMemReady=1 on the 4th cycle -> DECODE.
REQ-039 iRstN=0 during MEMWR -> oMemWrite=0 next cycle and state 0.
